// File: rtl/comb_pkg.sv
// Shared types and helpers for the combinational-circuit blocks.
// Occupancy encoding and the one-hot decode function live here.
package comb_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int MAXW = 256;

  // Widest entry; err sits in bit 0 so users slice the low WIDTH+1 bits.
  typedef struct packed {
    logic [MAXW-1:0] vec;
    logic            err;
  } dec_entry_t;

  function automatic dec_entry_t onehot_f(
    input logic [31:0] code,
    input logic        en,
    input int unsigned width
  );
    dec_entry_t r;
    r = '0;
    if (en) begin
      if (code < width) r.vec = MAXW'(1) << code;
      else r.err = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer.
// in_ready is registered; the main entry always drives out_data.
module skid_buf2
  import comb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  occ_e          occ_q, occ_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          rdy_q, rdy_d;
  logic          push, pop;

  assign push = in_valid & rdy_q;
  assign pop  = (occ_q != OCC_EMPTY) & out_ready;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          main_d = in_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d = in_data;
          occ_d  = OCC_FULL;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          main_d = skid_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    rdy_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with skid-buffered handshakes.
// Out-of-range codes are flagged and counted at accept.
module onehot_decoder_pipe
  import comb_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int OUT_BITS     = 3,
  parameter int ERR_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OUT_BITS-1:0]     in_code,
  input  logic                    in_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    out_err,
  output logic [ERR_CNT_BITS-1:0] err_count
);

  localparam int EW = WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] vec;
    logic             err;
  } dec_entry_t;

  dec_entry_t              dec_in, dec_out;
  logic                    push;
  logic [ERR_CNT_BITS-1:0] err_cnt_q, err_cnt_d;

  // Low bits of the wide entry line up with {vec[WIDTH-1:0], err}.
  assign dec_in = dec_entry_t'(EW'(onehot_f(32'(in_code), in_en, WIDTH)));

  skid_buf2 #(
    .DW(EW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (dec_out)
  );

  assign push = in_valid & in_ready;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && dec_in.err && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CNT_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end

  assign out       = dec_out.vec;
  assign out_err   = dec_out.err;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench: two decoder configurations driven in lockstep, checked
// against a queue-based model plus directed literal expectations.
module tb_onehot_decoder_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_en;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_err;
  logic [7:0] a_out;
  logic [7:0] a_err_count;
  logic       b_in_ready, b_out_valid, b_out_err;
  logic [5:0] b_out;
  logic [1:0] b_err_count;

  int checks = 0;
  int errors = 0;

  onehot_decoder_pipe #(
    .WIDTH(8), .OUT_BITS(3), .ERR_CNT_BITS(8)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_code(in_code), .in_en(in_en),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out(a_out), .out_err(a_out_err), .err_count(a_err_count)
  );

  onehot_decoder_pipe #(
    .WIDTH(6), .OUT_BITS(3), .ERR_CNT_BITS(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .in_en(in_en),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out(b_out), .out_err(b_out_err), .err_count(b_err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Entry = one-hot vector in low bits, error flag at bit 16.
  function automatic int dec_ref(int w, bit en, int code);
    if (!en) return 0;
    if (code < w) return 1 << code;
    return 1 << 16;
  endfunction

  function automatic int enc(logic [7:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = i;
    return r;
  endfunction

  int q0[$];
  int q1[$];
  int cnt0, cnt1;
  bit mpush, mpop;
  int e0, e1;

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    cnt0 = 0;
    cnt1 = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      mpush = in_valid && (q0.size() < 2);
      mpop  = (q0.size() > 0) && out_ready;
      if (mpop) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (mpush) begin
        e0 = dec_ref(8, in_en, int'(in_code));
        e1 = dec_ref(6, in_en, int'(in_code));
        q0.push_back(e0);
        q1.push_back(e1);
        if (e0[16] && cnt0 < 255) cnt0++;
        if (e1[16] && cnt1 < 3) cnt1++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_out", a_out, 0);
      chk("rst_a_cnt", a_err_count, 0);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_b_cnt", b_err_count, 0);
      chk("rst_a_ready", a_in_ready, 1);
    end else begin
      chk("m_a_ready", a_in_ready, int'(q0.size() < 2));
      chk("m_b_ready", b_in_ready, int'(q1.size() < 2));
      chk("m_a_valid", a_out_valid, int'(q0.size() > 0));
      chk("m_b_valid", b_out_valid, int'(q1.size() > 0));
      if (q0.size() > 0) begin
        chk("m_a_out", a_out, q0[0] & 'hff);
        chk("m_a_err", a_out_err, (q0[0] >> 16) & 1);
      end
      if (q1.size() > 0) begin
        chk("m_b_out", b_out, q1[0] & 'h3f);
        chk("m_b_err", b_out_err, (q1[0] >> 16) & 1);
      end
      chk("m_a_cnt", a_err_count, cnt0);
      chk("m_b_cnt", b_err_count, cnt1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int bad_codes[5] = '{6, 7, 6, 7, 6};
  int sat_exp[5]   = '{1, 2, 3, 3, 3};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    in_en     = 1'b0;
    out_ready = 1'b0;
    repeat (2) cyc();
    chk("lit_rst_ready", a_in_ready, 1);
    chk("lit_rst_out", a_out, 0);
    rst_n = 1'b1;
    cyc();
    chk("lit_rel_valid", a_out_valid, 0);

    // Stream codes 0..7 at full rate
    out_ready = 1'b1;
    in_en     = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_code = 3'(i);
      cyc();
      chk("lit_seq_out", a_out, 1 << i);
      chk("lit_seq_err", a_out_err, 0);
      chk("lit_seq_ready", a_in_ready, 1);
      chk("lit_roundtrip", enc(a_out), i);
      if (i == 2) chk("lit_b_code2", b_out, 'h04);
    end
    chk("lit_b_cnt2", b_err_count, 2);
    chk("lit_b_err7", b_out_err, 1);
    chk("lit_b_out7", b_out, 0);
    in_valid = 1'b0;
    cyc();

    // Backpressure: 3 then 5 fill the buffer, 6 waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'd3;
    cyc();
    chk("lit_bp_out3", a_out, 'h08);
    chk("lit_bp_rdy1", a_in_ready, 1);
    in_code = 3'd5;
    cyc();
    chk("lit_bp_full", a_in_ready, 0);
    chk("lit_bp_hold", a_out, 'h08);
    in_code = 3'd6;
    cyc();
    chk("lit_bp_hold2", a_out, 'h08);
    chk("lit_bp_noacc", a_in_ready, 0);
    out_ready = 1'b1;
    cyc();
    chk("lit_bp_out5", a_out, 'h20);
    chk("lit_bp_rdy2", a_in_ready, 1);
    cyc();
    chk("lit_bp_out6", a_out, 'h40);
    in_valid = 1'b0;
    cyc();
    chk("lit_bp_empty", a_out_valid, 0);

    // Disabled decode
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    in_en    = 1'b0;
    in_valid = 1'b1;
    in_code  = 3'd4;
    cyc();
    chk("lit_en0_out", a_out, 0);
    chk("lit_en0_err", a_out_err, 0);
    chk("lit_en0_vld", a_out_valid, 1);
    chk("lit_en0_cnt", b_err_count, 0);

    // Saturating error counter on the narrow instance
    in_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_code = 3'(bad_codes[i]);
      cyc();
      chk("lit_sat_cnt", b_err_count, sat_exp[i]);
    end
    in_valid = 1'b0;
    cyc();

    // Reset while stalled in FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'd6;
    cyc();
    in_code = 3'd7;
    cyc();
    chk("lit_stall_full", a_in_ready, 0);
    chk("lit_stall_cnt", b_err_count, 3);
    rst_n = 1'b0;
    #1;
    chk("lit_arst_valid", a_out_valid, 0);
    chk("lit_arst_out", a_out, 0);
    chk("lit_arst_cnt", b_err_count, 0);
    chk("lit_arst_bvld", b_out_valid, 0);
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("lit_arst_ready", a_in_ready, 1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_code   = 3'($urandom_range(0, 7));
      in_en     = 1'(($urandom % 8) != 0);
      out_ready = 1'(($urandom % 4) != 0);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("lit_drain", a_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
